// File: rtl/frame_capture_ctrl_if.sv
// frame_capture_ctrl_if: control, trigger and status bundle between a host and the frame capture sequencer
interface frame_capture_ctrl_if #(parameter int CNT_W = 8);
  logic arm;
  logic abort;
  logic [CNT_W-1:0] num_frames;
  logic trigger;
  logic capture_en;
  logic frame_start;
  logic [CNT_W-1:0] frame_cnt;
  logic busy;
  logic done;
  logic err_timeout;
  modport master (
    output arm, abort, num_frames, trigger,
    input  capture_en, frame_start, frame_cnt, busy, done, err_timeout
  );
  modport slave (
    input  arm, abort, num_frames, trigger,
    output capture_en, frame_start, frame_cnt, busy, done, err_timeout
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on request, captures N frames between trigger pulses, with watchdog abort
module frame_capture_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 24,
  parameter int TIMEOUT = 1000000
) (
  input logic clk,
  input logic reset_n,
  frame_capture_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] n_q;
  logic [TMO_W-1:0] timer;
  logic [CNT_W-1:0] cnt_nxt;
  logic tmo;
  assign cnt_nxt = bus.frame_cnt + 1'b1;
  assign tmo = timer == TMO_W'(TIMEOUT - 1);
  // abort beats trigger beats watchdog; frame_start and done are single-cycle strobes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      n_q             <= '0;
      timer           <= '0;
      bus.capture_en  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (bus.arm) begin
            bus.frame_cnt   <= '0;
            bus.err_timeout <= 1'b0;
            if (bus.num_frames != '0) begin
              n_q      <= bus.num_frames;
              state    <= WAIT;
              bus.busy <= 1'b1;
            end else
              bus.done <= 1'b1;
          end
        end
        WAIT:
          if (bus.abort) begin
            state    <= IDLE;
            timer    <= '0;
            bus.busy <= 1'b0;
          end else if (bus.trigger) begin
            state           <= CAPTURE;
            timer           <= '0;
            bus.capture_en  <= 1'b1;
            bus.frame_start <= 1'b1;
          end else if (tmo) begin
            state           <= IDLE;
            timer           <= '0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b1;
            bus.done        <= 1'b1;
          end else
            timer <= timer + 1'b1;
        CAPTURE:
          if (bus.abort) begin
            state          <= IDLE;
            timer          <= '0;
            bus.busy       <= 1'b0;
            bus.capture_en <= 1'b0;
          end else if (bus.trigger) begin
            timer         <= '0;
            bus.frame_cnt <= cnt_nxt;
            if (cnt_nxt == n_q) begin
              state          <= IDLE;
              bus.busy       <= 1'b0;
              bus.capture_en <= 1'b0;
              bus.done       <= 1'b1;
            end else
              bus.frame_start <= 1'b1;
          end else if (tmo) begin
            state           <= IDLE;
            timer           <= '0;
            bus.busy        <= 1'b0;
            bus.capture_en  <= 1'b0;
            bus.err_timeout <= 1'b1;
            bus.done        <= 1'b1;
          end else
            timer <= timer + 1'b1;
        default: begin
          state          <= IDLE;
          timer          <= '0;
          bus.busy       <= 1'b0;
          bus.capture_en <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: directed checks of the frame capture sequencer with long and short watchdogs
module tb_frame_capture_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  frame_capture_ctrl_if #(.CNT_W(8)) la ();
  frame_capture_ctrl_if #(.CNT_W(8)) wd ();
  frame_capture_ctrl #(.CNT_W(8), .TMO_W(24), .TIMEOUT(1000000)) u_long (
    .clk(clk), .reset_n(reset_n), .bus(la.slave));
  frame_capture_ctrl #(.CNT_W(8), .TMO_W(24), .TIMEOUT(16)) u_wd (
    .clk(clk), .reset_n(reset_n), .bus(wd.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_la"}, {la.capture_en, la.frame_start, la.busy, la.done, la.err_timeout, la.frame_cnt}, 0);
    chk({tag, "_wd"}, {wd.capture_en, wd.frame_start, wd.busy, wd.done, wd.err_timeout, wd.frame_cnt}, 0);
  endtask
  initial begin
    la.arm = 0; la.abort = 0; la.num_frames = 0; la.trigger = 0;
    wd.arm = 0; wd.abort = 0; wd.num_frames = 0; wd.trigger = 0;
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");
    // nominal n=3, triggers at 10,30,50,70 after arm edge 0
    la.arm = 1; la.num_frames = 8'd3;
    tick();
    la.arm = 0;
    chk("nom_busy0", la.busy, 1);
    for (int k = 1; k <= 75; k++) begin
      la.trigger = (k == 10 || k == 30 || k == 50 || k == 70);
      tick();
      chk("nom_fs", la.frame_start, (k == 10 || k == 30 || k == 50));
      chk("nom_cap", la.capture_en, (k >= 10 && k < 70));
      chk("nom_done", la.done, (k == 70));
      chk("nom_busy", la.busy, (k < 70));
    end
    la.trigger = 0;
    chk("nom_cnt", la.frame_cnt, 3);
    // zero request
    la.arm = 1; la.num_frames = 8'd0;
    tick();
    la.arm = 0;
    chk("zero_done", la.done, 1);
    chk("zero_busy", la.busy, 0);
    chk("zero_cnt", la.frame_cnt, 0);
    tick();
    chk("zero_done_clr", la.done, 0);
    chk("zero_busy2", la.busy, 0);
    // watchdog with no trigger
    wd.arm = 1; wd.num_frames = 8'd2;
    tick();
    wd.arm = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("wd_done", wd.done, (k == 16));
      chk("wd_err", wd.err_timeout, (k >= 16));
      chk("wd_busy", wd.busy, (k < 16));
    end
    // re-arm clears error, then mid-capture timeout with n=5
    wd.arm = 1; wd.num_frames = 8'd5;
    tick();
    wd.arm = 0;
    chk("rearm_err", wd.err_timeout, 0);
    chk("rearm_busy", wd.busy, 1);
    for (int k = 1; k <= 22; k++) begin
      wd.trigger = (k == 2 || k == 4);
      tick();
      chk("mid_cap", wd.capture_en, (k >= 2 && k < 20));
      chk("mid_done", wd.done, (k == 20));
      chk("mid_err", wd.err_timeout, (k >= 20));
    end
    wd.trigger = 0;
    chk("mid_cnt", wd.frame_cnt, 1);
    // arm while busy is ignored; back-to-back triggers each counted
    la.arm = 1; la.num_frames = 8'd4;
    tick();
    for (int k = 1; k <= 8; k++) begin
      la.arm = (k == 1);
      la.num_frames = (k == 1) ? 8'd9 : 8'd4;
      la.trigger = (k >= 2 && k <= 6);
      tick();
      chk("b2b_done", la.done, (k == 6));
      chk("b2b_busy", la.busy, (k < 6));
      chk("b2b_fs", la.frame_start, (k >= 2 && k <= 5));
      chk("b2b_cnt", la.frame_cnt, (k <= 2) ? 0 : (k >= 6) ? 4 : k - 2);
    end
    la.arm = 0; la.trigger = 0;
    // abort coincident with second trigger
    la.arm = 1; la.num_frames = 8'd4;
    tick();
    la.arm = 0;
    for (int k = 1; k <= 6; k++) begin
      la.trigger = (k == 2 || k == 4);
      la.abort = (k == 4);
      tick();
      chk("abt_cap", la.capture_en, (k >= 2 && k < 4));
      chk("abt_busy", la.busy, (k < 4));
      chk("abt_done", la.done, 0);
      chk("abt_cnt", la.frame_cnt, 0);
      chk("abt_err", la.err_timeout, 0);
    end
    la.trigger = 0; la.abort = 0;
    // asynchronous reset mid-capture
    la.arm = 1; la.num_frames = 8'd5;
    tick();
    la.arm = 0;
    for (int k = 1; k <= 3; k++) begin
      la.trigger = (k >= 2);
      tick();
    end
    la.trigger = 0;
    chk("rst_pre_cap", la.capture_en, 1);
    chk("rst_pre_cnt", la.frame_cnt, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async_cap", la.capture_en, 0);
    chk("rst_async_busy", la.busy, 0);
    chk("rst_async_cnt", la.frame_cnt, 0);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rst_no_done", la.done, 0);
      chk("rst_idle", la.busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Frame-capture sequencer that sits directly downstream of the trigger edge detector.
- Consumes its 1-cycle `trigger` pulses (frame-sync falling edges) and, once armed, opens a capture window spanning exactly N frames.
- Emits per-frame start pulses, a completed-frame count, and a done pulse.
- A watchdog aborts the sequence if frame sync stops arriving.

Parameters:
- CNT_W, 8, width of frame-count request and counter.
- TMO_W, 24, width of watchdog timer.
- TIMEOUT, 1000000, max clocks allowed between triggers (WAIT or CAPTURE) before timeout; must be ≥2 and <2^TMO_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  start request, sampled each clk, level treated as pulse.
- abort  in  1  cancel request.
- num_frames  in  CNT_W  frames to capture; sampled only when arm is accepted.
- trigger  in  1  single-cycle frame-boundary pulse, already synchronised.
- capture_en  out  1  high while frames are being captured.
- frame_start  out  1  1-cycle pulse at the start of each captured frame.
- frame_cnt  out  CNT_W  frames completed in the current/last sequence.
- busy  out  1  high in WAIT or CAPTURE.
- done  out  1  1-cycle pulse at normal completion or timeout.
- err_timeout  out  1  sticky; set on watchdog expiry, cleared on next accepted arm.

Behaviour:
- Reset: all outputs 0, state IDLE, latched count 0, timer 0.
- All outputs are registered. An event sampled at edge t is visible after edge t+1.
- States: IDLE, WAIT, CAPTURE. busy = (state != IDLE).
- IDLE:
  - arm=1 and num_frames!=0: latch n=num_frames, frame_cnt←0, timer←0, err_timeout←0, go WAIT.
  - arm=1 and num_frames==0: done pulses, frame_cnt←0, err_timeout←0, stay IDLE.
  - trigger and abort are ignored.
- WAIT:
  - trigger: go CAPTURE, capture_en←1, frame_start pulses, timer←0.
  - Otherwise timer increments.
  - timer==TIMEOUT-1 with no trigger: go IDLE, err_timeout←1, done pulses.
- CAPTURE:
  - trigger: frame_cnt←frame_cnt+1, timer←0.
    - If frame_cnt+1==n: go IDLE, capture_en←0, done pulses, no frame_start.
    - Else: frame_start pulses, capture_en stays 1.
  - No trigger: timer increments. At timer==TIMEOUT-1: go IDLE, capture_en←0, err_timeout←1, done pulses, frame_cnt holds the partial count.
- Priority in WAIT/CAPTURE: abort > trigger > timeout.
  - abort: go IDLE next cycle, capture_en←0, no done, err_timeout unchanged, frame_cnt holds.
- arm while busy: ignored, and num_frames is not re-sampled.
- Trigger and timeout in the same cycle: the trigger wins and the timer clears.
- Watchdog: the timer never wraps and is only live in WAIT/CAPTURE. It is held at 0 in IDLE.
- frame_cnt arithmetic is CNT_W-bit unsigned. n ≤ 2^CNT_W-1, so no overflow occurs.
- frame_cnt remains stable after completion until the next accepted arm.
- Asynchronous reset mid-sequence returns immediately to reset values: capture_en drops with no done pulse.
- trigger pulses arriving back-to-back on consecutive cycles are each counted.

Test Plan:
- Nominal, n=3: arm, then triggers at clocks 10, 30, 50, 70.
  - capture_en high from 11 to 71; frame_start at 11, 31, 51.
  - done at 71, frame_cnt=3, busy low at 71.
- Zero request: arm with num_frames=0 → done pulse next cycle, busy never asserts, frame_cnt=0.
- Watchdog, TIMEOUT=16: arm, no trigger → done and err_timeout=1 exactly 16 cycles after entering WAIT, busy=0.
  - Re-arm clears err_timeout.
- Mid-capture timeout, n=5, TIMEOUT=16: 2 triggers, then silence → capture_en falls, err_timeout=1, frame_cnt=1.
- Abort priority, n=4: assert abort coincident with the 2nd trigger → capture_en falls next cycle, no done, frame_cnt=0, err_timeout=0.
  - Arm while busy with num_frames=9 is ignored; latched n stays 4.
- Reset mid-capture: assert reset_n=0 between clock edges during CAPTURE → capture_en, busy and frame_cnt go 0 asynchronously, and no done follows release.
